// File: rtl/tdm_demux_1to4_if.sv
// Bus bundle for the 1-to-4 TDM demux: upstream beat channel, lane outputs and frame handshake.
// frame_cnt_out exists only when TDM_DEMUX_FRAME_CNT_EN is defined.
interface tdm_demux_1to4_if #(
    parameter int unsigned WIDTH = 1
);
    logic [WIDTH-1:0]   d_in;
    logic               valid_in;
    logic               ready_out;
    logic [1:0]         sel_in;
    logic               mode_in;
    logic [4*WIDTH-1:0] y_out;
    logic [3:0]         lane_valid_out;
    logic               frame_valid_out;
    logic               frame_ack_in;
    logic               overrun_out;
`ifdef TDM_DEMUX_FRAME_CNT_EN
    logic [7:0]         frame_cnt_out;
`endif

    // Upstream source / downstream sink side
    modport master (
`ifdef TDM_DEMUX_FRAME_CNT_EN
        input  frame_cnt_out,
`endif
        output d_in, valid_in, sel_in, mode_in, frame_ack_in,
        input  ready_out, y_out, lane_valid_out, frame_valid_out, overrun_out
    );

    // Demux side
    modport slave (
`ifdef TDM_DEMUX_FRAME_CNT_EN
        output frame_cnt_out,
`endif
        input  d_in, valid_in, sel_in, mode_in, frame_ack_in,
        output ready_out, y_out, lane_valid_out, frame_valid_out, overrun_out
    );
endinterface

// File: rtl/tdm_demux_1to4.sv
// Registered 1-to-4 TDM demultiplexer: steers beats into four lane registers (addressed or
// round-robin) and holds a complete frame until acked. Define TDM_DEMUX_FRAME_CNT_EN for an 8-bit acked-frame counter.
module tdm_demux_1to4 #(
    parameter int unsigned WIDTH = 1
) (
    input logic             clk_in,
    input logic             rst_n_in,
    tdm_demux_1to4_if.slave bus
);
    localparam int unsigned LANES = 4;
    localparam int unsigned SEL_W = 2;
    localparam int unsigned CNT_W = 8;

    logic [LANES*WIDTH-1:0] y_q, y_d;
    logic [LANES-1:0]       lv_q, lv_d;
    logic                   ov_q, ov_d;
    logic [SEL_W-1:0]       ptr_q, ptr_d;

    logic                   frame_valid_c;
    logic                   ready_c;
    logic                   accept_c;
    logic                   ack_c;
    logic [SEL_W-1:0]       lane_c;

`ifdef TDM_DEMUX_FRAME_CNT_EN
    logic [CNT_W-1:0]       cnt_q, cnt_d;
`endif

    // Handshake decode; an acked frame restarts round-robin at lane 0 with no bubble
    always_comb begin
        frame_valid_c = &lv_q;
        ready_c       = !frame_valid_c || bus.frame_ack_in;
        accept_c      = bus.valid_in && ready_c;
        ack_c         = frame_valid_c && bus.frame_ack_in;
        lane_c        = bus.mode_in ? (ack_c ? SEL_W'(0) : ptr_q) : bus.sel_in;
    end

    // Next-state: ack clears the valid flags first, then an accepted beat sets its lane
    always_comb begin
        y_d   = y_q;
        lv_d  = ack_c ? '0 : lv_q;
        ov_d  = 1'b0;
        ptr_d = ptr_q;
        if (accept_c) begin
            y_d[32'(lane_c)*WIDTH +: WIDTH] = bus.d_in;
            lv_d[lane_c] = 1'b1;
            ov_d = !bus.mode_in && !ack_c && lv_q[lane_c];
        end
        if (!bus.mode_in) begin
            ptr_d = '0;
        end else if (accept_c) begin
            ptr_d = lane_c + SEL_W'(1);
        end else if (ack_c) begin
            ptr_d = '0;
        end
    end

`ifdef TDM_DEMUX_FRAME_CNT_EN
    always_comb begin
        cnt_d = ack_c ? cnt_q + CNT_W'(1) : cnt_q;
    end
`endif

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            y_q   <= '0;
            lv_q  <= '0;
            ov_q  <= 1'b0;
            ptr_q <= '0;
        end else begin
            y_q   <= y_d;
            lv_q  <= lv_d;
            ov_q  <= ov_d;
            ptr_q <= ptr_d;
        end
    end

`ifdef TDM_DEMUX_FRAME_CNT_EN
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.frame_cnt_out = cnt_q;
`endif

    assign bus.y_out           = y_q;
    assign bus.lane_valid_out  = lv_q;
    assign bus.overrun_out     = ov_q;
    assign bus.frame_valid_out = frame_valid_c;
    assign bus.ready_out       = ready_c;
endmodule

// File: tb/tb_tdm_demux_1to4.sv
// Scoreboard bench for tdm_demux_1to4 (WIDTH = 4): the driver queues hand-computed expectations
// per cycle, a negedge monitor pops and compares them against the DUT outputs.
module tb_tdm_demux_1to4;
    localparam int unsigned WIDTH = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tdm_demux_1to4_if #(.WIDTH(WIDTH)) bus ();

    tdm_demux_1to4 #(.WIDTH(WIDTH)) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus.slave)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_bad = 0;
    int step_id = 0;

    typedef struct {
        int          cyc;
        int          id;
        logic [15:0] y;
        logic [3:0]  lv;
        logic        fv;
        logic        rdy;
        logic        ov;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s vec%0d: got %0h expected %0h", name, id, act, exp);
        end
    endtask

    // Drive one cycle of inputs and queue what must be observed during this cycle
    task automatic step(input logic v, input logic [3:0] d, input logic [1:0] sel, input logic m,
                        input logic ack, input logic [15:0] ey, input logic [3:0] elv,
                        input logic efv, input logic erdy, input logic eov);
        exp_t e;
        bus.valid_in     = v;
        bus.d_in         = d;
        bus.sel_in       = sel;
        bus.mode_in      = m;
        bus.frame_ack_in = ack;
        e.cyc = cyc;
        e.id  = step_id;
        e.y   = ey;
        e.lv  = elv;
        e.fv  = efv;
        e.rdy = erdy;
        e.ov  = eov;
        sb.push_back(e);
        step_id++;
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_reset(input int id);
        check("rst_y",   id, 32'(bus.y_out),           32'h0);
        check("rst_lv",  id, 32'(bus.lane_valid_out),  32'h0);
        check("rst_fv",  id, 32'(bus.frame_valid_out), 32'h0);
        check("rst_ov",  id, 32'(bus.overrun_out),     32'h0);
        check("rst_rdy", id, 32'(bus.ready_out),       32'h1);
    endtask

    // Monitor: compare every queued expectation on the negedge of its cycle
    initial begin
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                exp_t e;
                e = sb.pop_front();
                check("sched", e.id, 32'(e.cyc), 32'(cyc));
                check("y",     e.id, 32'(bus.y_out),           32'(e.y));
                check("lv",    e.id, 32'(bus.lane_valid_out),  32'(e.lv));
                check("fv",    e.id, 32'(bus.frame_valid_out), 32'(e.fv));
                check("rdy",   e.id, 32'(bus.ready_out),       32'(e.rdy));
                check("ov",    e.id, 32'(bus.overrun_out),     32'(e.ov));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.valid_in     = 1'b0;
        bus.d_in         = '0;
        bus.sel_in       = '0;
        bus.mode_in      = 1'b0;
        bus.frame_ack_in = 1'b0;
        #2;
        check_idle_reset(-1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        //   v     d     sel   m     ack   y         lv       fv    rdy   ov
        // Addressed writes to lane 2, second one overruns
        step(1'b1, 4'h7, 2'd2, 1'b0, 1'b0, 16'h0000, 4'b0000, 1'b0, 1'b1, 1'b0);
        step(1'b1, 4'h9, 2'd2, 1'b0, 1'b0, 16'h0700, 4'b0100, 1'b0, 1'b1, 1'b0);
        step(1'b0, 4'h0, 2'd0, 1'b1, 1'b0, 16'h0900, 4'b0100, 1'b0, 1'b1, 1'b1);
        // Round-robin frame A,5,3,C; rewrite of lane 2 must not flag overrun
        step(1'b1, 4'hA, 2'd0, 1'b1, 1'b0, 16'h0900, 4'b0100, 1'b0, 1'b1, 1'b0);
        step(1'b1, 4'h5, 2'd0, 1'b1, 1'b0, 16'h090A, 4'b0101, 1'b0, 1'b1, 1'b0);
        step(1'b1, 4'h3, 2'd0, 1'b1, 1'b0, 16'h095A, 4'b0111, 1'b0, 1'b1, 1'b0);
        step(1'b1, 4'hC, 2'd0, 1'b1, 1'b0, 16'h035A, 4'b0111, 1'b0, 1'b1, 1'b0);
        // Full frame held, beats offered without ack are refused
        step(1'b1, 4'hF, 2'd0, 1'b1, 1'b0, 16'hC35A, 4'b1111, 1'b1, 1'b0, 1'b0);
        step(1'b1, 4'hF, 2'd0, 1'b1, 1'b0, 16'hC35A, 4'b1111, 1'b1, 1'b0, 1'b0);
        step(1'b1, 4'hF, 2'd0, 1'b1, 1'b0, 16'hC35A, 4'b1111, 1'b1, 1'b0, 1'b0);
        // Ack with simultaneous beat: lane 0 = E, pointer continues at lane 1
        step(1'b1, 4'hE, 2'd0, 1'b1, 1'b1, 16'hC35A, 4'b1111, 1'b1, 1'b1, 1'b0);
        step(1'b1, 4'h2, 2'd0, 1'b1, 1'b0, 16'hC35E, 4'b0001, 1'b0, 1'b1, 1'b0);
        step(1'b0, 4'h0, 2'd0, 1'b1, 1'b0, 16'hC32E, 4'b0011, 1'b0, 1'b1, 1'b0);

        // Asynchronous reset mid-cycle after two round-robin beats
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_reset(-2);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        step(1'b1, 4'h6, 2'd0, 1'b1, 1'b0, 16'h0000, 4'b0000, 1'b0, 1'b1, 1'b0);
        // Ack while no frame is held is ignored
        step(1'b0, 4'h0, 2'd0, 1'b1, 1'b1, 16'h0006, 4'b0001, 1'b0, 1'b1, 1'b0);
        step(1'b1, 4'hB, 2'd0, 1'b1, 1'b0, 16'h0006, 4'b0001, 1'b0, 1'b1, 1'b0);
        step(1'b1, 4'h1, 2'd0, 1'b1, 1'b0, 16'h00B6, 4'b0011, 1'b0, 1'b1, 1'b0);
        step(1'b1, 4'h8, 2'd0, 1'b1, 1'b0, 16'h01B6, 4'b0111, 1'b0, 1'b1, 1'b0);
        // Plain ack: flags clear, data retained
        step(1'b0, 4'h0, 2'd0, 1'b1, 1'b0, 16'h81B6, 4'b1111, 1'b1, 1'b0, 1'b0);
        step(1'b0, 4'h0, 2'd0, 1'b1, 1'b1, 16'h81B6, 4'b1111, 1'b1, 1'b1, 1'b0);
        step(1'b1, 4'h4, 2'd0, 1'b1, 1'b0, 16'h81B6, 4'b0000, 1'b0, 1'b1, 1'b0);
        step(1'b0, 4'h0, 2'd0, 1'b1, 1'b0, 16'h81B4, 4'b0001, 1'b0, 1'b1, 1'b0);

`ifdef TDM_DEMUX_FRAME_CNT_EN
        #2;
        rst_n = 1'b0;
        #1;
        check("cnt_rst", -3, 32'(bus.frame_cnt_out), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.mode_in = 1'b1;
        for (int f = 0; f < 257; f++) begin
            for (int b = 0; b < 4; b++) begin
                bus.valid_in     = 1'b1;
                bus.d_in         = 4'(b);
                bus.frame_ack_in = 1'b0;
                @(posedge clk);
                #1;
            end
            bus.valid_in     = 1'b0;
            bus.frame_ack_in = 1'b1;
            @(posedge clk);
            #1;
            bus.frame_ack_in = 1'b0;
        end
        check("cnt_wrap", -4, 32'(bus.frame_cnt_out), 32'h1);
`endif

        bus.valid_in     = 1'b0;
        bus.frame_ack_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("sb_drain", -5, 32'(sb.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
